// File: rtl/chia_xung_if.sv
// Output bundle of the chia_xung pulse divider: divided clock, rise strobe, count.
// Latency: none (wires only); every signal is driven from a flop in the divider.
// Backpressure: none; the divider free-runs and consumers sample when they like.
//   clko : divided square wave, low for floor(DIV/2) cycles then high for the rest
//   tick : one-clki-cycle strobe coincident with the first high cycle of clko
//   cnt  : current divider count, 0..DIV-1
interface chia_xung_if;
  logic       clko;
  logic       tick;
  logic [3:0] cnt;

  // master: the divider that produces the signals
  modport master (
    output clko,
    output tick,
    output cnt
  );

  // slave: any block consuming the divided clock / strobe
  modport slave (
    input clko,
    input tick,
    input cnt
  );
endinterface

// File: rtl/chia_xung.sv
// Clock divider by DIV (2..16) for the pulse-generator subsystem; drives clko/tick/cnt.
// Latency: outputs are flops loaded from the next count, so they change on the same clki edge as cnt.
// Backpressure: none; free-running, only rst_n (async, active-low) stops and clears it.
//   clki  : input clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset, release is taken on the next clki rise
//   bus   : chia_xung_if.master carrying clko, tick and cnt
module chia_xung #(
  parameter int DIV = 16
) (
  input  logic        clki,
  input  logic        rst_n,
  chia_xung_if.master bus
);

  // A 4-bit counter cannot represent more than 16 states, and DIV < 2 has no
  // meaningful low/high phase, so reject those at elaboration.
  if (DIV < 2 || DIV > 16) begin : g_div_check
    $error("chia_xung: DIV must be in the range 2..16");
  end

  localparam int         LOW    = DIV / 2;
  localparam logic [3:0] LAST_C = 4'(DIV - 1);
  localparam logic [3:0] LOW_C  = 4'(LOW);

  logic [3:0] cnt_q;
  logic [3:0] cnt_next;
  logic       clko_q;
  logic       tick_q;

  // Wrap at DIV-1; for DIV=16 this is the same as natural 4-bit overflow.
  always_comb begin
    cnt_next = (cnt_q == LAST_C) ? 4'd0 : cnt_q + 4'd1;
  end

  // clko/tick are decoded from cnt_next rather than cnt_q so that they are
  // registered (glitch-free, no input-to-output path) yet line up with the
  // count value they describe.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      clko_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      clko_q <= (cnt_next >= LOW_C);
      tick_q <= (cnt_next == LOW_C);
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.clko = clko_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_chia_xung.sv
// Self-checking bench for chia_xung at DIV = 16, 5 and 2 sharing one clock and reset.
// Latency: reference expects outputs to reflect k = number of clki rises since reset release.
// Backpressure: not applicable; the bench only drives clki and rst_n.
`timescale 1ns/100ps
module tb_chia_xung;

  logic clki  = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: count of rising edges seen with rst_n high since the last reset.
  int k = 0;

  chia_xung_if b16 ();
  chia_xung_if b5 ();
  chia_xung_if b2 ();

  chia_xung #(.DIV(16)) u_div16 (.clki(clki), .rst_n(rst_n), .bus(b16));
  chia_xung #(.DIV(5))  u_div5  (.clki(clki), .rst_n(rst_n), .bus(b5));
  chia_xung #(.DIV(2))  u_div2  (.clki(clki), .rst_n(rst_n), .bus(b2));

  always #5 clki = ~clki;

  always @(posedge clki or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected outputs straight from the arithmetic definition.
  function automatic int exp_cnt(input int div, input int edges);
    return edges % div;
  endfunction
  function automatic int exp_clko(input int div, input int edges);
    return ((edges % div) >= (div / 2)) ? 1 : 0;
  endfunction
  function automatic int exp_tick(input int div, input int edges);
    return ((edges % div) == (div / 2)) ? 1 : 0;
  endfunction

  // Continuous comparison on the falling edge, away from the active edge.
  bit chk_en = 1'b1;
  always @(negedge clki) begin
    if (chk_en) begin
      check_eq("cnt16",  int'(b16.cnt),  exp_cnt(16, k));
      check_eq("clko16", int'(b16.clko), exp_clko(16, k));
      check_eq("tick16", int'(b16.tick), exp_tick(16, k));
      check_eq("cnt5",   int'(b5.cnt),   exp_cnt(5, k));
      check_eq("clko5",  int'(b5.clko),  exp_clko(5, k));
      check_eq("tick5",  int'(b5.tick),  exp_tick(5, k));
      check_eq("cnt2",   int'(b2.cnt),   exp_cnt(2, k));
      check_eq("clko2",  int'(b2.clko),  exp_clko(2, k));
      check_eq("tick2",  int'(b2.tick),  exp_tick(2, k));
    end
  end

  // Reset is asserted a few ns after a rising edge; outputs must already be clear.
  task automatic async_reset(input string tag);
    @(posedge clki);
    #($urandom_range(1, 4));
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_cnt16"},  int'(b16.cnt),  0);
    check_eq({tag, "_clko16"}, int'(b16.clko), 0);
    check_eq({tag, "_tick16"}, int'(b16.tick), 0);
    check_eq({tag, "_cnt5"},   int'(b5.cnt),   0);
    check_eq({tag, "_clko5"},  int'(b5.clko),  0);
    check_eq({tag, "_cnt2"},   int'(b2.cnt),   0);
    check_eq({tag, "_clko2"},  int'(b2.clko),  0);
  endtask

  // Wait (bounded) for b16.clko to reach a level; timestamp in ns.
  task automatic wait_clko16(input logic level, output real t, output bit ok);
    ok = 1'b0;
    t  = 0.0;
    for (int i = 0; i < 400; i++) begin
      if (b16.clko === level) begin
        ok = 1'b1;
        t  = $realtime;
        break;
      end
      #1;
    end
  endtask

  initial begin
    real t0, t1, t2;
    bit  ok;

    // Reset hold: 100 ns of toggling clki with rst_n low.
    #100;
    check_eq("hold_cnt16",  int'(b16.cnt),  0);
    check_eq("hold_clko16", int'(b16.clko), 0);

    // Default run: 64 cycles after release.
    @(negedge clki);
    rst_n = 1'b1;
    repeat (64) @(posedge clki);
    @(negedge clki);

    // Mid-high asynchronous reset after edge 11.
    async_reset("rst0");
    @(negedge clki);
    rst_n = 1'b1;
    repeat (11) @(posedge clki);
    #2;
    check_eq("midhigh_clko16", int'(b16.clko), 1);
    async_reset("midhigh");
    repeat (2) @(posedge clki);
    #3;
    rst_n = 1'b1;
    repeat (30) @(posedge clki);

    // Random run lengths and reset points.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 40)) @(posedge clki);
      async_reset("rnd");
      repeat ($urandom_range(0, 3)) @(posedge clki);
      @(posedge clki);
      #($urandom_range(1, 4));
      rst_n = 1'b1;
    end

    // Period / duty of clko at DIV=16 over 10 periods.
    repeat (5) @(posedge clki);
    @(negedge clki);
    #0.5;
    wait_clko16(1'b0, t0, ok);
    if (ok) wait_clko16(1'b1, t0, ok);
    check_eq("clko16_first_rise", int'(ok), 1);
    for (int p = 0; p < 10 && ok; p++) begin
      wait_clko16(1'b0, t1, ok);
      check_eq("clko16_fall_seen", int'(ok), 1);
      if (ok) wait_clko16(1'b1, t2, ok);
      check_eq("clko16_rise_seen", int'(ok), 1);
      if (ok) begin
        check_eq("clko16_high_ns",   int'(t1 - t0), 80);
        check_eq("clko16_period_ns", int'(t2 - t0), 160);
        t0 = t2;
      end
    end

    @(negedge clki);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
